accum_sched: RTL
================

ACCUM_SCHED -- requirements
Module: accum_sched

Interface
REQ-001 CLOCK  input  1  system clock; all state updates on rising edge.
REQ-002 RESETn  input  1  reset, synchronous, active-low.
REQ-003 req  input  2  per-requester job request, level-sensitive; bit i = requester i.
REQ-004 x0, x1  input  5 each  addend for requester 0/1.
REQ-005 y0, y1  input  5 each  repeat count for requester 0/1.
REQ-006 acc_sum  input  10  current value of the external accumulator register.
REQ-007 acc_clr  output  1  accumulator clear; accumulator loads 0 at the next edge.
REQ-008 acc_en  output  1  accumulator add enable; accumulator adds acc_x at the next edge.
REQ-009 acc_x  output  5  addend presented to the accumulator.
REQ-010 gnt  output  2  one-hot grant, held from LOAD through DONE.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 done  output  2  one-cycle completion pulse for the granted requester.
REQ-013 result  output  10  last completed product; holds until the next completion.

Function
REQ-014 FSM states SHALL be IDLE, LOAD, RUN and DONE; internal regs: op_x[4:0], cnt[4:0], last[0:0] (last served requester).
REQ-015 IDLE: no req -> stay; otherwise grant sel; if exactly one req bit is set, sel is that requester; if both are set, sel = ~last.
REQ-016 IDLE->LOAD edge: op_x <= x_sel, cnt <= y_sel, gnt <= onehot(sel), last <= sel.
REQ-017 LOAD (1 cycle): acc_clr=1, acc_en=0; -> RUN.
REQ-018 RUN: acc_en = (cnt != 0), acc_x = op_x; when cnt != 0, cnt <= cnt-1 and stay in RUN.
REQ-019 RUN with cnt == 0: acc_en=0; result <= acc_sum at that edge; -> DONE.
REQ-020 DONE (1 cycle): done[sel]=1, result valid; -> IDLE with gnt cleared.
REQ-021 acc_x SHALL equal op_x in all non-IDLE states and 0 in IDLE; acc_clr and acc_en are never high simultaneously.
REQ-022 Latency: req sampled in IDLE at cycle t -> LOAD t+1 -> RUN t+2..t+y+2 -> done pulse at cycle t+y+3.
REQ-023 Product x*y SHALL be at most 961 and fit in 10 bits; no overflow handling is required.
REQ-024 y == 0: LOAD, a single RUN cycle with no acc_en, then result = 0.
REQ-025 Operands are latched at grant; changes to x/y/req during a job SHALL be ignored, and a dropped req does not abort the job.
REQ-026 req still high in IDLE after done SHALL be treated as a new request, subject to round-robin.
REQ-027 With both requests held continuously, grants SHALL alternate 0,1,0,1,...
REQ-028 Each gap between jobs SHALL be exactly one IDLE cycle.

Reset
REQ-029 RESETn low at an edge: state=IDLE, gnt=0, done=0, busy=0, acc_clr=0, acc_en=0, acc_x=0, result=0, cnt=0, op_x=0, last=1 (requester 0 wins the first tie).
REQ-030 Reset SHALL override any state, including mid-RUN; the aborted job produces no done pulse and no result update.

Verification
Bench models the accumulator as a register: clear on acc_clr, add acc_x on acc_en, drive its value on acc_sum.
REQ-031 Single request: req0 with x0=5, y0=3, req high at cycle t -> acc_en high for 3 cycles, done[0] at t+6, result=15.
REQ-032 Simultaneous first request: req=2'b11 after reset -> gnt=01 first; if both requests stay held, gnt=10 next, then 01.
REQ-033 Zero count: x1=7, y1=0 -> acc_en is never asserted, done[1] at t+3, result=0.
REQ-034 Maximum operands: x0=31, y0=31 -> result=961, done at t+34.
REQ-035 Reset in RUN: RESETn low for 1 cycle mid-job -> all outputs 0 the next cycle and no done pulse; a later req=11 grants requester 0.
REQ-036 Operand change: x0 changes from 5 to 9 during RUN -> result still 5*y0; busy high from LOAD through DONE.

Source files
------------

// File: rtl/accum_sched.sv
// -----------------------------------------------------------------------------
// accum_sched
//   Multiplies x*y by repeated addition on an external accumulator register,
//   arbitrating between two requesters with round-robin on ties. One job runs
//   at a time: LOAD clears the accumulator, RUN adds the latched addend once
//   per remaining count, and DONE pulses completion for the granted requester.
//
// Ports
//   CLOCK    in   system clock, rising edge
//   RESETn   in   synchronous active-low reset
//   req      in   [1:0] level-sensitive job request, bit i = requester i
//   x0, x1   in   [4:0] addend per requester
//   y0, y1   in   [4:0] repeat count per requester
//   acc_sum  in   [9:0] current accumulator value
//   acc_clr  out  accumulator loads 0 at next edge
//   acc_en   out  accumulator adds acc_x at next edge
//   acc_x    out  [4:0] addend presented to the accumulator
//   gnt      out  [1:0] one-hot grant, held LOAD through DONE
//   busy     out  high whenever not IDLE
//   done     out  [1:0] one-cycle completion pulse for the granted requester
//   result   out  [9:0] last completed product, held until the next completion
// -----------------------------------------------------------------------------
module accum_sched (
  input  logic       CLOCK,
  input  logic       RESETn,
  input  logic [1:0] req,
  input  logic [4:0] x0,
  input  logic [4:0] x1,
  input  logic [4:0] y0,
  input  logic [4:0] y1,
  input  logic [9:0] acc_sum,
  output logic       acc_clr,
  output logic       acc_en,
  output logic [4:0] acc_x,
  output logic [1:0] gnt,
  output logic       busy,
  output logic [1:0] done,
  output logic [9:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] op_x_q, op_x_d;
  logic [4:0] cnt_q, cnt_d;
  logic       last_q, last_d;
  logic [1:0] gnt_q, gnt_d;
  logic [9:0] result_q, result_d;
  logic       sel;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge CLOCK) begin
    if (!RESETn) begin
      state_q  <= S_IDLE;
      op_x_q   <= '0;
      cnt_q    <= '0;
      last_q   <= 1'b1;  // requester 0 wins the first tie after reset
      gnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_x_q   <= op_x_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      result_q <= result_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    op_x_d   = op_x_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    result_d = result_q;
    sel      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          // A lone request wins outright; a tie goes to whoever was not
          // served last.
          sel     = (req == 2'b11) ? ~last_q : req[1];
          op_x_d  = sel ? x1 : x0;
          cnt_d   = sel ? y1 : y0;
          gnt_d   = sel ? 2'b10 : 2'b01;
          last_d  = sel;
          state_d = S_LOAD;
        end
      end
      S_LOAD: state_d = S_RUN;
      S_RUN: begin
        if (cnt_q != 5'd0) begin
          cnt_d = cnt_q - 5'd1;
        end else begin
          // All additions have landed, so acc_sum now holds x*y.
          result_d = acc_sum;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        gnt_d   = 2'b00;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign acc_clr = (state_q == S_LOAD);
  assign acc_en  = (state_q == S_RUN) && (cnt_q != 5'd0);
  assign acc_x   = busy ? op_x_q : 5'd0;
  assign gnt     = gnt_q;
  assign done    = (state_q == S_DONE) ? gnt_q : 2'b00;
  assign result  = result_q;

endmodule
